// File: rtl/hps_job_handshake_ctrl_if.sv
// Handshake bundle between the HPS PIO side / TPU controller and the job sequencer.
// The sequencer uses the slave view; the driver of cmd_req/tpu_done uses master.
interface hps_job_handshake_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             cmd_req;
    logic             tpu_done;
    logic             tpu_start;
    logic             status_to_hps;
    logic             error;
    logic [CNT_W-1:0] job_cycles;
    logic [2:0]       state_dbg;

    modport slave (
        input  cmd_req, tpu_done,
        output tpu_start, status_to_hps, error, job_cycles, state_dbg
    );

    modport master (
        output cmd_req, tpu_done,
        input  tpu_start, status_to_hps, error, job_cycles, state_dbg
    );
endinterface

// File: rtl/hps_job_handshake_ctrl.sv
// Four-phase HPS job sequencer: one TPU start per request edge, status held until
// the request is withdrawn, with job duration and sticky timeout diagnostics.
module hps_job_handshake_ctrl #(
    parameter int          SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int          CNT_W          = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    hps_job_handshake_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BUSY  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       jc_q, jc_d;
    logic                   err_q, err_d;
    logic                   req_s;
    logic [CNT_W-1:0]       cnt_inc;

    assign req_s   = sync_q[SYNC_STAGES-1];
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= bus.cmd_req;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            jc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            jc_q    <= jc_d;
            err_q   <= err_d;
        end
    end

    // Counter and error are cleared on the way into START so the START cycle
    // already shows error=0 and BUSY begins counting from 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        jc_d    = jc_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_START: state_d = S_BUSY;
            S_BUSY: begin
                cnt_d = cnt_inc;
                if (bus.tpu_done) begin
                    jc_d    = cnt_inc;
                    state_d = S_DONE;
                end else if (TO_EN && cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (!req_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.tpu_start     = (state_q == S_START);
    assign bus.status_to_hps = (state_q == S_DONE) || (state_q == S_ERR);
    assign bus.error         = err_q;
    assign bus.job_cycles    = jc_q;
    assign bus.state_dbg     = state_q;

endmodule
